// File: rtl/rej_ntt_sampler_if.sv
// Stream bundle between the squeeze source, the rejection sampler and its coefficient sink.
// The sampler takes the slave side; whoever drives words and consumes coefficients takes master.
interface rej_ntt_sampler_if #(
  parameter int W       = 64,
  parameter int COEFF_W = 23
);
  logic               start;
  logic [W-1:0]       data_in;
  logic               valid_in;
  logic               ready_out;
  logic [COEFF_W-1:0] coeff_out;
  logic               coeff_valid;
  logic               coeff_ready;
  logic [7:0]         coeff_index;
  logic               done;

  modport master (
    output start, data_in, valid_in, coeff_ready,
    input  ready_out, coeff_out, coeff_valid, coeff_index, done
  );

  modport slave (
    input  start, data_in, valid_in, coeff_ready,
    output ready_out, coeff_out, coeff_valid, coeff_index, done
  );
endinterface

// File: rtl/rej_ntt_sampler.sv
// Dilithium uniform rejection sampler: packs the squeeze byte stream into 3-byte
// candidates, masks to 23 bits, keeps those below Q and streams N coefficients out.
module rej_ntt_sampler #(
  parameter int W       = 64,
  parameter int COEFF_W = 23,
  parameter int Q       = 8380417,
  parameter int N       = 256
) (
  input  logic               clk,
  input  logic               rst,
  rej_ntt_sampler_if.slave   bus
);

  localparam int BUF_W  = W + 16;
  localparam int CNT_W  = $clog2(BUF_W / 8 + 1);
  localparam int KEPT_W = $clog2(N + 1);
  localparam logic [KEPT_W-1:0] KEPT_N = KEPT_W'(N);

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEPT_W-1:0]  kept_q, kept_d;
  logic [COEFF_W-1:0] coeff_out_q, coeff_out_d;
  logic               coeff_valid_q, coeff_valid_d;
  logic [7:0]         coeff_index_q, coeff_index_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic               accept;
  logic               take;
  logic               extract;
  logic [COEFF_W-1:0] cand;

  // Low 23 bits of the buffer are b0, b1 and b2[6:0]; b2[7] is dropped by the slice.
  assign cand    = buf_q[COEFF_W-1:0];
  assign accept  = bus.valid_in && ready_q;
  assign take    = coeff_valid_q && bus.coeff_ready;
  assign extract = (state_q == SAMPLE) && (cnt_q >= CNT_W'(3)) &&
                   (!coeff_valid_q || bus.coeff_ready) && (kept_q < KEPT_N);

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    kept_d        = kept_q;
    coeff_out_d   = coeff_out_q;
    coeff_valid_d = coeff_valid_q;
    coeff_index_d = coeff_index_q;

    case (state_q)
      IDLE, DONE: begin
        // Words arriving in DONE are accepted and simply dropped.
        if (bus.start) begin
          state_d       = SAMPLE;
          buf_d         = '0;
          cnt_d         = '0;
          kept_d        = '0;
          coeff_valid_d = 1'b0;
        end
      end
      SAMPLE: begin
        if (take) begin
          coeff_valid_d = 1'b0;
          if (kept_q == KEPT_N && coeff_index_q == 8'(N - 1))
            state_d = DONE;
        end
        // ready_q is only high here when cnt<3, so accept and extract never coincide.
        if (accept) begin
          buf_d = buf_q | (BUF_W'(bus.data_in) << {cnt_q, 3'b000});
          cnt_d = cnt_q + CNT_W'(8);
        end else if (extract) begin
          buf_d = buf_q >> 24;
          cnt_d = cnt_q - CNT_W'(3);
          if (cand < COEFF_W'(Q)) begin
            coeff_out_d   = cand;
            coeff_valid_d = 1'b1;
            coeff_index_d = kept_q[7:0];
            kept_d        = kept_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = ((state_d == SAMPLE) && (cnt_d < CNT_W'(3))) || (state_d == DONE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      cnt_q         <= '0;
      kept_q        <= '0;
      coeff_out_q   <= '0;
      coeff_valid_q <= 1'b0;
      coeff_index_q <= '0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      kept_q        <= kept_d;
      coeff_out_q   <= coeff_out_d;
      coeff_valid_q <= coeff_valid_d;
      coeff_index_q <= coeff_index_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
    end
  end

  assign bus.ready_out   = ready_q;
  assign bus.coeff_out   = coeff_out_q;
  assign bus.coeff_valid = coeff_valid_q;
  assign bus.coeff_index = coeff_index_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_rej_ntt_sampler.sv
// Directed bench for rej_ntt_sampler: hand-built byte streams with known outcomes,
// then a random stream checked against a byte-level rejection model.
module tb_rej_ntt_sampler;

  localparam int W = 64;
  localparam int COEFF_W = 23;
  localparam int Q = 8380417;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rej_ntt_sampler_if #(.W(W), .COEFF_W(COEFF_W)) bus ();

  rej_ntt_sampler #(.W(W), .COEFF_W(COEFF_W), .Q(Q), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit rand_ready = 1'b0;

  logic [22:0] got_val [$];
  logic [7:0]  got_idx [$];
  logic [63:0] words   [$];
  logic [22:0] expv    [$];
  logic [7:0]  bq      [$];
  logic [63:0] t4w     [3];
  int          wt;
  int          wi;
  logic [23:0] c24;
  logic [63:0] rw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) begin
      pass_cnt++;
      total_cnt++;
    end else begin
      total_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records the coefficient handshake due at the coming edge, then moves to 1ns past it.
  task automatic tick();
    if (!rst && bus.coeff_valid && bus.coeff_ready) begin
      got_val.push_back(bus.coeff_out);
      got_idx.push_back(bus.coeff_index);
    end
    @(posedge clk);
    #1;
    if (rand_ready) bus.coeff_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input logic [63:0] w, output int waited);
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    waited = 0;
    while (!bus.ready_out && waited < 60) begin
      tick();
      waited++;
    end
    if (waited >= 60) chk("send_timeout", 64'(bus.ready_out), 64'd1);
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_poly();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    got_val.delete();
    got_idx.delete();
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.coeff_ready = 1'b1;

    // Reset state
    reset_dut();
    tick();
    chk("rst_ready",   64'(bus.ready_out),   64'd0);
    chk("rst_cvalid",  64'(bus.coeff_valid), 64'd0);
    chk("rst_done",    64'(bus.done),        64'd0);
    chk("rst_coeff",   64'(bus.coeff_out),   64'd0);
    chk("rst_index",   64'(bus.coeff_index), 64'd0);

    // T1: bytes 01 00 00 | 02 00 00 | 00 00 -> coeffs 1, 2 with two residue bytes
    start_poly();
    chk("t1_ready_after_start", 64'(bus.ready_out), 64'd1);
    send_word(64'h0000_0000_0200_0001, wt);
    chk("t1_wait", 64'(wt), 64'd0);
    chk("t1_ready_low_after_accept", 64'(bus.ready_out), 64'd0);
    repeat (4) tick();
    chk("t1_count", 64'(got_val.size()), 64'd2);
    chk("t1_val0",  64'(got_val[0]), 64'd1);
    chk("t1_idx0",  64'(got_idx[0]), 64'd0);
    chk("t1_val1",  64'(got_val[1]), 64'd2);
    chk("t1_idx1",  64'(got_idx[1]), 64'd1);
    chk("t1_ready_residue", 64'(bus.ready_out), 64'd1);
    chk("t1_cvalid_idle",   64'(bus.coeff_valid), 64'd0);

    // T2: FF FF FF (8388607) and 01 E0 7F (=Q) rejected, 00 E0 7F (Q-1) kept
    reset_dut();
    start_poly();
    send_word(64'hE000_7FE0_01FF_FFFF, wt);
    send_word(64'h00FF_FFFF_FFFF_FF7F, wt);
    repeat (8) tick();
    chk("t2_count", 64'(got_val.size()), 64'd1);
    chk("t2_val0",  64'(got_val[0]), 64'd8380416);
    chk("t2_idx0",  64'(got_idx[0]), 64'd0);

    // T3: FF FF 80 has bit 23 set; masked value 0x00FFFF is kept
    reset_dut();
    start_poly();
    send_word(64'h0000_80FF_FF80_FFFF, wt);
    repeat (6) tick();
    chk("t3_count", 64'(got_val.size()), 64'd2);
    chk("t3_val0",  64'(got_val[0]), 64'd65535);
    chk("t3_val1",  64'(got_val[1]), 64'd65535);
    chk("t3_idx1",  64'(got_idx[1]), 64'd1);

    // T4: repeating 01 00 00 over 3 words; residue 2,1,0 sets the ready wait per word
    reset_dut();
    start_poly();
    t4w[0] = 64'h0001_0000_0100_0001;
    t4w[1] = 64'h0100_0001_0000_0100;
    t4w[2] = 64'h0000_0100_0001_0000;
    send_word(t4w[0], wt);
    chk("t4_wait0", 64'(wt), 64'd0);
    chk("t4_ready_low0", 64'(bus.ready_out), 64'd0);
    send_word(t4w[1], wt);
    chk("t4_wait1", 64'(wt), 64'd2);
    chk("t4_ready_low1", 64'(bus.ready_out), 64'd0);
    send_word(t4w[2], wt);
    chk("t4_wait2", 64'(wt), 64'd3);
    chk("t4_ready_low2", 64'(bus.ready_out), 64'd0);
    repeat (6) tick();
    chk("t4_count", 64'(got_val.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t4_val", 64'(got_val[i]), 64'd1);
      chk("t4_idx", 64'(got_idx[i]), 64'(i));
    end
    chk("t4_ready_empty", 64'(bus.ready_out), 64'd1);

    // T5: downstream stall holds the first coefficient and blocks extraction
    reset_dut();
    start_poly();
    bus.coeff_ready = 1'b0;
    send_word(64'h0807_0000_0600_0005, wt);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_val",    64'(bus.coeff_out),   64'd5);
      chk("t5_hold_idx",    64'(bus.coeff_index), 64'd0);
      chk("t5_hold_valid",  64'(bus.coeff_valid), 64'd1);
      chk("t5_hold_ready",  64'(bus.ready_out),   64'd0);
      tick();
    end
    bus.coeff_ready = 1'b1;
    send_word(64'h0000_0000_0000_0009, wt);
    repeat (8) tick();
    chk("t5_count", 64'(got_val.size()), 64'd5);
    chk("t5_val0",  64'(got_val[0]), 64'd5);
    chk("t5_val1",  64'(got_val[1]), 64'd6);
    chk("t5_val2",  64'(got_val[2]), 64'h090807);
    chk("t5_val3",  64'(got_val[3]), 64'd0);
    chk("t5_val4",  64'(got_val[4]), 64'd0);
    chk("t5_idx4",  64'(got_idx[4]), 64'd4);

    // T6: random stream; model accumulates bytes and applies rejection independently
    while (expv.size() < N) begin
      rw = {$urandom, $urandom};
      words.push_back(rw);
      for (int b = 0; b < 8; b++) bq.push_back(rw[8*b +: 8]);
      while (bq.size() >= 3 && expv.size() < N) begin
        c24 = {bq[2], bq[1], bq[0]};
        void'(bq.pop_front());
        void'(bq.pop_front());
        void'(bq.pop_front());
        if (c24[22:0] < 23'(Q)) expv.push_back(c24[22:0]);
      end
    end
    for (int i = 0; i < 4; i++) words.push_back({$urandom, $urandom});

    // Abandon a polynomial once 100 coefficients are out
    reset_dut();
    start_poly();
    rand_ready = 1'b1;
    wi = 0;
    while (got_val.size() < 100 && wi < words.size()) begin
      send_word(words[wi], wt);
      wi++;
    end
    chk("t6_partial_reached", 64'(got_val.size() >= 100), 64'd1);
    chk("t6_partial_val99",   64'(got_val[99]), 64'(expv[99]));
    rand_ready = 1'b0;
    bus.coeff_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("t6_rst_done",   64'(bus.done),        64'd0);
    chk("t6_rst_cvalid", 64'(bus.coeff_valid), 64'd0);
    chk("t6_rst_ready",  64'(bus.ready_out),   64'd0);
    rst = 1'b0;
    tick();

    // Restart and run the full polynomial plus surplus words
    start_poly();
    rand_ready = 1'b1;
    for (int i = 0; i < words.size(); i++) send_word(words[i], wt);
    rand_ready = 1'b0;
    bus.coeff_ready = 1'b1;
    repeat (20) tick();
    chk("t6_count", 64'(got_val.size()), 64'(N));
    for (int i = 0; i < N && i < got_val.size(); i++) begin
      chk("t6_val", 64'(got_val[i]), 64'(expv[i]));
      chk("t6_idx", 64'(got_idx[i]), 64'(i));
    end
    chk("t6_done",       64'(bus.done),      64'd1);
    chk("t6_done_ready", 64'(bus.ready_out), 64'd1);

    // start from DONE drops done on the next cycle and re-opens sampling
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t6_restart_done",  64'(bus.done),      64'd0);
    chk("t6_restart_ready", 64'(bus.ready_out), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
